// File: rtl/gray_step_tracker.sv
// gray_step_tracker
// Receive side of a Gray-coded count path. The incoming Gray word is passed
// through a multi-flop synchroniser, decoded to binary, registered, and every
// sample-to-sample change is classified as up, down, hold or illegal skip.
// A lock state machine and a saturating error counter report link health.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   reset      - asynchronous, active-high reset
//   gray_in    - Gray word, asynchronous to clk
//   clear_err  - synchronous request to clear err_count
//   bin_out    - decoded binary value, registered
//   bin_valid  - bin_out holds a decoded post-reset sample
//   step_up    - one-cycle pulse, bin_out = previous + 1 (mod 2^DATA_WIDTH)
//   step_down  - one-cycle pulse, bin_out = previous - 1 (mod 2^DATA_WIDTH)
//   skip_err   - one-cycle pulse, change other than +/-1
//   locked     - lock state machine is in TRACK
//   err_count  - saturating count of skip_err pulses
module gray_step_tracker #(
  parameter int DATA_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int RELOCK      = 4,
  parameter int ERR_W       = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] gray_in,
  input  logic                  clear_err,
  output logic [DATA_WIDTH-1:0] bin_out,
  output logic                  bin_valid,
  output logic                  step_up,
  output logic                  step_down,
  output logic                  skip_err,
  output logic                  locked,
  output logic [ERR_W-1:0]      err_count
);

  localparam int FILL_W   = $clog2(SYNC_STAGES + 1);
  localparam int RELOCK_W = $clog2(RELOCK + 1);
  localparam logic [FILL_W-1:0]   FILL_DONE  = FILL_W'(SYNC_STAGES);
  localparam logic [RELOCK_W-1:0] RELOCK_MAX = RELOCK_W'(RELOCK);
  localparam logic [ERR_W-1:0]    ERR_MAX    = '1;

  typedef enum logic [1:0] {
    ACQUIRE,
    TRACK,
    FAULT
  } state_t;

  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];

  logic [DATA_WIDTH-1:0] binOut_q,    binOut_d;
  logic                  binValid_q,  binValid_d;
  logic                  stepUp_q,    stepUp_d;
  logic                  stepDown_q,  stepDown_d;
  logic                  skipErr_q,   skipErr_d;
  logic [ERR_W-1:0]      errCount_q,  errCount_d;
  logic [FILL_W-1:0]     fillCnt_q,   fillCnt_d;
  logic [RELOCK_W-1:0]   relockCnt_q, relockCnt_d;
  state_t                state_q,     state_d;

  logic [DATA_WIDTH-1:0] newBin;
  logic [DATA_WIDTH-1:0] prevPlus;
  logic [DATA_WIDTH-1:0] prevMinus;
  logic                  loadEn;
  logic                  legalSample;

  // Prefix XOR from the MSB down turns a Gray word back into binary.
  function automatic logic [DATA_WIDTH-1:0] grayToBin(input logic [DATA_WIDTH-1:0] g);
    logic [DATA_WIDTH-1:0] b;
    b[DATA_WIDTH-1] = g[DATA_WIDTH-1];
    for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Plain flop chain; nothing looks at the word until it leaves the last stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign newBin    = grayToBin(sync_q[SYNC_STAGES-1]);
  assign prevPlus  = binOut_q + DATA_WIDTH'(1);
  assign prevMinus = binOut_q - DATA_WIDTH'(1);

  // The fill counter stops at SYNC_STAGES, at which point the last sync stage
  // holds a post-reset sample and the decode register may start loading.
  assign loadEn = (fillCnt_q == FILL_DONE);

  always_comb begin
    binOut_d    = binOut_q;
    binValid_d  = binValid_q;
    stepUp_d    = 1'b0;
    stepDown_d  = 1'b0;
    skipErr_d   = 1'b0;
    fillCnt_d   = fillCnt_q;
    relockCnt_d = relockCnt_q;
    state_d     = state_q;
    errCount_d  = errCount_q;
    legalSample = 1'b0;

    if (!loadEn) begin
      fillCnt_d = fillCnt_q + FILL_W'(1);
    end

    // The first loaded sample only seeds the reference; it never pulses.
    if (loadEn) begin
      binOut_d   = newBin;
      binValid_d = 1'b1;
      if (binValid_q) begin
        if (newBin == binOut_q) begin
          legalSample = 1'b1;
        end else if (newBin == prevPlus) begin
          stepUp_d    = 1'b1;
          legalSample = 1'b1;
        end else if (newBin == prevMinus) begin
          stepDown_d  = 1'b1;
          legalSample = 1'b1;
        end else begin
          skipErr_d = 1'b1;
        end
      end
    end

    case (state_q)
      ACQUIRE: begin
        relockCnt_d = '0;
        if (loadEn) begin
          state_d = TRACK;
        end
      end
      TRACK: begin
        if (skipErr_d) begin
          state_d     = FAULT;
          relockCnt_d = '0;
        end
      end
      FAULT: begin
        if (skipErr_d) begin
          relockCnt_d = '0;
        end else if (legalSample) begin
          if (relockCnt_q + RELOCK_W'(1) == RELOCK_MAX) begin
            state_d     = TRACK;
            relockCnt_d = '0;
          end else begin
            relockCnt_d = relockCnt_q + RELOCK_W'(1);
          end
        end
      end
      default: begin
        state_d     = ACQUIRE;
        relockCnt_d = '0;
      end
    endcase

    // A clear coinciding with a skip still records that skip.
    if (clear_err) begin
      errCount_d = skipErr_d ? ERR_W'(1) : '0;
    end else if (skipErr_d && (errCount_q != ERR_MAX)) begin
      errCount_d = errCount_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      binOut_q    <= '0;
      binValid_q  <= 1'b0;
      stepUp_q    <= 1'b0;
      stepDown_q  <= 1'b0;
      skipErr_q   <= 1'b0;
      errCount_q  <= '0;
      fillCnt_q   <= '0;
      relockCnt_q <= '0;
      state_q     <= ACQUIRE;
    end else begin
      binOut_q    <= binOut_d;
      binValid_q  <= binValid_d;
      stepUp_q    <= stepUp_d;
      stepDown_q  <= stepDown_d;
      skipErr_q   <= skipErr_d;
      errCount_q  <= errCount_d;
      fillCnt_q   <= fillCnt_d;
      relockCnt_q <= relockCnt_d;
      state_q     <= state_d;
    end
  end

  assign bin_out   = binOut_q;
  assign bin_valid = binValid_q;
  assign step_up   = stepUp_q;
  assign step_down = stepDown_q;
  assign skip_err  = skipErr_q;
  assign locked    = (state_q == TRACK);
  assign err_count = errCount_q;

endmodule

// File: tb/tb_gray_step_tracker.sv
// tb_gray_step_tracker
// Scoreboard bench for gray_step_tracker. The driver applies one input word
// per cycle, runs the reference model for the edge that will sample it, and
// queues the expected outputs; a monitor pops one entry after every edge and
// compares it with what the DUT shows. The model works on plain integers:
// a delay queue for the synchroniser, shift-XOR Gray decode and modular
// differences for classification.
module tb_gray_step_tracker;

  localparam int W       = 4;
  localparam int S       = 2;
  localparam int RL      = 4;
  localparam int EW      = 2;
  localparam int MASK    = (1 << W) - 1;
  localparam int ERR_MAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  gray_in = '0;
  logic          clear_err = 1'b0;
  logic [W-1:0]  bin_out;
  logic          bin_valid;
  logic          step_up;
  logic          step_down;
  logic          skip_err;
  logic          locked;
  logic [EW-1:0] err_count;

  gray_step_tracker #(
    .DATA_WIDTH (W),
    .SYNC_STAGES(S),
    .RELOCK     (RL),
    .ERR_W      (EW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .gray_in  (gray_in),
    .clear_err(clear_err),
    .bin_out  (bin_out),
    .bin_valid(bin_valid),
    .step_up  (step_up),
    .step_down(step_down),
    .skip_err (skip_err),
    .locked   (locked),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bin;
    int valid;
    int up;
    int down;
    int skip;
    int lock;
    int err;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;

  // reference model state
  int pipe[$];
  int mBin;
  int mErr;
  int mRun;
  bit mValid;
  bit mLocked;
  int curBin;

  function automatic int grayToBinRef(input int g);
    int b;
    b = 0;
    for (int s = 0; s < W; s++) b = b ^ (g >> s);
    return b & MASK;
  endfunction

  function automatic int binToGray(input int b);
    return (b ^ (b >> 1)) & MASK;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int required);
    total++;
    if (actual != required) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, required, $time);
    end
  endtask

  task automatic modelReset();
    pipe.delete();
    mBin    = 0;
    mErr    = 0;
    mRun    = 0;
    mValid  = 1'b0;
    mLocked = 1'b0;
  endtask

  // Expected outputs after the edge that samples (g, clr).
  task automatic modelEdge(input int g, input bit clr);
    exp_t e;
    int   n;
    int   d;
    bit   up;
    bit   down;
    bit   skip;
    up   = 1'b0;
    down = 1'b0;
    skip = 1'b0;
    pipe.push_back(g);
    if (pipe.size() > S) begin
      n = grayToBinRef(pipe.pop_front());
      if (!mValid) begin
        mValid  = 1'b1;
        mLocked = 1'b1;
        mRun    = 0;
      end else begin
        d = (n - mBin) & MASK;
        if (d == 1) up = 1'b1;
        else if (d == MASK) down = 1'b1;
        else if (d != 0) skip = 1'b1;
        if (skip) begin
          mLocked = 1'b0;
          mRun    = 0;
        end else if (!mLocked) begin
          mRun++;
          if (mRun == RL) begin
            mLocked = 1'b1;
            mRun    = 0;
          end
        end
      end
      mBin = n;
    end
    if (clr) mErr = skip ? 1 : 0;
    else if (skip && mErr < ERR_MAX) mErr++;
    e.bin   = mBin;
    e.valid = int'(mValid);
    e.up    = int'(up);
    e.down  = int'(down);
    e.skip  = int'(skip);
    e.lock  = int'(mLocked);
    e.err   = mErr;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input int g, input bit clr);
    @(negedge clk);
    gray_in   = g[W-1:0];
    clear_err = clr;
    modelEdge(g, clr);
  endtask

  task automatic driveBin(input int b, input int cycles);
    repeat (cycles) applyStimulus(binToGray(b & MASK), 1'b0);
    curBin = b & MASK;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " bin_out"},   int'(bin_out),   0);
    checkOutput({tag, " bin_valid"}, int'(bin_valid), 0);
    checkOutput({tag, " step_up"},   int'(step_up),   0);
    checkOutput({tag, " step_down"}, int'(step_down), 0);
    checkOutput({tag, " skip_err"},  int'(skip_err),  0);
    checkOutput({tag, " locked"},    int'(locked),    0);
    checkOutput({tag, " err_count"}, int'(err_count), 0);
  endtask

  // Release lands on a negedge together with the first post-reset input,
  // so the very first rising edge after release already has an expectation.
  task automatic releaseReset(input int b);
    @(negedge clk);
    reset     = 1'b0;
    gray_in   = W'(binToGray(b));
    clear_err = 1'b0;
    modelReset();
    modelEdge(binToGray(b), 1'b0);
    curBin = b;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkAllZero("midreset");
    expQ.delete();
    modelReset();
    @(negedge clk);
  endtask

  // monitor: one expected entry per rising edge, compared just after it
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("bin_out",   int'(bin_out),   e.bin);
        checkOutput("bin_valid", int'(bin_valid), e.valid);
        checkOutput("step_up",   int'(step_up),   e.up);
        checkOutput("step_down", int'(step_down), e.down);
        checkOutput("skip_err",  int'(skip_err),  e.skip);
        checkOutput("locked",    int'(locked),    e.lock);
        checkOutput("err_count", int'(err_count), e.err);
      end
    end
  end

  initial begin
    int choice;
    int hold;
    int nextBin;
    bit clr;

    modelReset();
    repeat (2) @(negedge clk);
    #1;
    checkAllZero("reset");

    // reset release with a constant zero input
    releaseReset(0);
    driveBin(0, 5);

    // up count with wrap 15 -> 0
    for (int b = 1; b <= 16; b++) driveBin(b, 2);

    // down count, starting with the 0 -> 15 wrap
    driveBin(15, 2);
    for (int b = 14; b >= 0; b--) driveBin(b, 2);
    driveBin(15, 2);

    // single skip 1 -> 4 then stable input until relock
    driveBin(1, 4);
    driveBin(4, 8);

    // relock interrupted: skip, two legal samples, another skip
    driveBin(9, 3);
    driveBin(12, 8);

    // saturation of the narrow error counter
    driveBin(0, 2);
    driveBin(8, 2);
    driveBin(0, 2);
    driveBin(8, 2);
    driveBin(0, 2);

    // clear_err coinciding with the edge that loads a skip
    applyStimulus(binToGray(8), 1'b0);
    applyStimulus(binToGray(8), 1'b0);
    applyStimulus(binToGray(8), 1'b1);
    driveBin(8, 2);

    // clear_err alone
    applyStimulus(binToGray(8), 1'b1);
    driveBin(8, 3);

    // reset while a step_up pulse is showing
    driveBin(9, 3);
    pulseReset();
    releaseReset(5);
    driveBin(5, 4);

    // randomized phase
    for (int k = 0; k < 150; k++) begin
      choice = $urandom_range(0, 9);
      hold   = $urandom_range(1, 3);
      if (choice <= 3) nextBin = curBin;
      else if (choice <= 5) nextBin = (curBin + 1) & MASK;
      else if (choice <= 7) nextBin = (curBin - 1) & MASK;
      else nextBin = $urandom_range(0, MASK);
      for (int c = 0; c < hold; c++) begin
        clr = ($urandom_range(0, 15) == 0);
        applyStimulus(binToGray(nextBin), clr);
      end
      curBin = nextBin;
      if (k == 75) begin
        pulseReset();
        releaseReset($urandom_range(0, MASK));
      end
    end

    // let the scoreboard drain, with a bound
    for (int c = 0; c < 10 && expQ.size() > 0; c++) @(posedge clk);
    @(posedge clk);
    #2;
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_step_tracker.md
# gray_step_tracker

Receive side of the Gray-coded count path. The block takes a Gray code word from an asynchronous Gray counter, synchronises it, decodes it back to binary and classifies every sample-to-sample change as up, down, hold or illegal skip. A lock state machine and a saturating error counter report link health to the consuming logic.

## Interface

- DATA_WIDTH, 4, width of the Gray/binary word (≥2)
- SYNC_STAGES, 2, synchroniser flop stages on gray_in (≥2)
- RELOCK, 4, consecutive legal samples in FAULT needed to return to TRACK (≥1)
- ERR_W, 8, err_count width
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clock clk
- gray_in  input  DATA_WIDTH  Gray word, asynchronous to clk, single-bit changes only when legal
- clear_err  input  1  synchronous request to clear err_count
- bin_out  output  DATA_WIDTH  decoded binary value, registered
- bin_valid  output  1  bin_out holds a decoded sample
- step_up  output  1  one-cycle pulse: bin_out = previous + 1 (mod 2^DATA_WIDTH)
- step_down  output  1  one-cycle pulse: bin_out = previous − 1 (mod 2^DATA_WIDTH)
- skip_err  output  1  one-cycle pulse: change other than ±1
- locked  output  1  state is TRACK
- err_count  output  ERR_W  saturating count of skip_err pulses

## Operation

- Synchroniser: SYNC_STAGES-flop chain per bit; no decoding before the last stage.
- Decode: b[MSB] = g[MSB]; b[i] = b[i+1] ^ g[i]; result of the last sync stage registered into bin_out.
- Fill counter: bin_valid rises once the sync chain and decode register hold post-reset samples. After that, bin_valid stays 1 until reset.
- Classification compares the new decoded value n against the current bin_out p, at the edge that loads n:
  - n == p: hold; no pulse.
  - n == p+1 mod 2^W: step_up (wrap max→0 is up).
  - n == p−1 mod 2^W: step_down (wrap 0→max is down).
  - otherwise: skip_err.
  - At most one of step_up/step_down/skip_err is high in any cycle.
- The first valid sample after reset is a reference only; no pulse.
- State machine:
  - ACQUIRE (reset state): on first valid sample go to TRACK.
  - TRACK: a skip goes to FAULT; the locked drop and skip_err are in the same cycle.
  - FAULT: a legal sample (hold/up/down) increments the relock counter. A skip zeroes it. When the counter reaches RELOCK, go to TRACK and clear the counter.
  - Step pulses are still emitted in FAULT.
- err_count: +1 per skip_err, saturating at 2^ERR_W−1. clear_err sets it to 0. If clear_err and skip_err fall in the same cycle, the result is 1.
- Reset mid-operation: all state returns to reset values immediately, and the fill sequence restarts on deassertion.

## Timing

- Reset values: bin_out=0, bin_valid=0, step_up=0, step_down=0, skip_err=0, locked=0, err_count=0, sync flops=0, state=ACQUIRE.
- Latency: a gray_in change sampled at edge k appears on bin_out, with its pulse, at edge k+SYNC_STAGES.
- bin_valid rises at the (SYNC_STAGES+1)th rising edge after reset deasserts. locked rises at the same edge.
- Pulses last exactly one cycle. Consecutive changes on consecutive cycles give consecutive pulses.
- In FAULT with RELOCK=4, locked rises at the edge that loads the 4th consecutive legal sample. Holds count as legal, so relock takes 4 cycles when the input is stable.
- clear_err takes effect at the next edge.

## Test plan

- Reset values: assert reset mid-run and check every output is 0 immediately. Release reset with gray_in=0 constant: bin_valid=1 and locked=1 at edge 3, and no pulses.
- Up count with wrap (W=4): drive the Gray sequence 0000,0001,0011,…,1000,0000, one step per 2 cycles. bin_out follows 0..15,0 with 2-cycle latency, giving 16 step_up pulses including 15→0. skip_err stays 0.
- Down count with wrap: start from 0 and drive Gray 1000 (binary 15) then descend. One step_down per change, including 0→15, and no step_up.
- Skip: in TRACK, jump gray_in 0001→0110 (binary 1→4). Expect skip_err, locked=0 and err_count=1 in the same cycle. Hold input stable: locked=1 exactly 4 cycles later.
- Relock interrupted: in FAULT, give 2 legal samples then another skip. Expect err_count=2 and a relock counter restart, so locked rises only after 4 further legal samples.
- err_count: with ERR_W=2, inject 5 skips and check err_count holds at 3. Assert clear_err together with a skip and check err_count=1. Assert clear_err alone and check err_count=0.
